// File: rtl/eth_rx_mac_filter.sv
// Receive-side destination MAC filter: buffers the 6-byte destination address,
// then replays and forwards matching frames or silently drops the rest.
module eth_rx_mac_filter #(
    parameter int COUNTER_WIDTH = 32,
    parameter bit FILTER_ENABLE = 1'b1
) (
    input  logic                     clock50,
    input  logic                     reset_n,
    input  logic [47:0]              local_mac,
    input  logic                     cfg_promiscuous,
    input  logic                     cfg_accept_broadcast,
    input  logic                     cfg_accept_multicast,
    input  logic [7:0]               s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tuser,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    input  logic                     stat_clear,
    output logic [COUNTER_WIDTH-1:0] stat_frames_accepted,
    output logic [COUNTER_WIDTH-1:0] stat_frames_dropped
);

    typedef enum logic [1:0] {HDR, REPLAY, PASS, DROP} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               idx_q, idx_d;
    logic [2:0]               r_q, r_d;
    logic [7:0]               hdr_q [6];
    logic [7:0]               hdr_d [6];
    logic [COUNTER_WIDTH-1:0] acc_q, acc_d;
    logic [COUNTER_WIDTH-1:0] drop_q, drop_d;

    logic        s_hs, m_hs;
    logic        acc_inc, drop_inc;
    logic [47:0] dest;
    logic        is_bcast, match;

    // Output muxing is combinational so PASS adds no latency or bubbles.
    always_comb begin
        s_axis_tready = 1'b1;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        unique case (state_q)
            HDR:    s_axis_tready = 1'b1;
            REPLAY: begin
                s_axis_tready = 1'b0;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_q[r_q];
            end
            PASS: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
            end
            DROP:   s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b1;
        endcase
    end

    assign m_axis_tkeep = 1'b1;
    assign s_hs = s_axis_tvalid & s_axis_tready;
    assign m_hs = m_axis_tvalid & m_axis_tready;

    // The 6th byte is still on the bus when the match is evaluated.
    assign dest     = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], s_axis_tdata};
    assign is_bcast = (dest == 48'hFFFF_FFFF_FFFF);
    assign match    = !FILTER_ENABLE || cfg_promiscuous || (dest == local_mac)
                    || (is_bcast && cfg_accept_broadcast)
                    || (hdr_q[0][0] && !is_bcast && cfg_accept_multicast);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        r_d      = r_q;
        hdr_d    = hdr_q;
        acc_inc  = 1'b0;
        drop_inc = 1'b0;
        unique case (state_q)
            HDR: begin
                if (s_hs) begin
                    hdr_d[idx_q] = s_axis_tdata;
                    if (s_axis_tlast) begin
                        drop_inc = 1'b1;
                        idx_d    = '0;
                    end else if (idx_q == 3'd5) begin
                        idx_d   = '0;
                        r_d     = '0;
                        state_d = match ? REPLAY : DROP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            REPLAY: begin
                if (m_hs) begin
                    if (r_q == 3'd5) begin
                        r_d     = '0;
                        state_d = PASS;
                    end else begin
                        r_d = r_q + 3'd1;
                    end
                end
            end
            PASS: begin
                if (s_hs && s_axis_tlast) begin
                    acc_inc = 1'b1;
                    idx_d   = '0;
                    state_d = HDR;
                end
            end
            DROP: begin
                if (s_hs && s_axis_tlast) begin
                    drop_inc = 1'b1;
                    idx_d    = '0;
                    state_d  = HDR;
                end
            end
            default: state_d = HDR;
        endcase
    end

    // Clear wins over a same-cycle increment.
    always_comb begin
        if (stat_clear) begin
            acc_d  = '0;
            drop_d = '0;
        end else begin
            acc_d  = acc_q + {{(COUNTER_WIDTH-1){1'b0}}, acc_inc};
            drop_d = drop_q + {{(COUNTER_WIDTH-1){1'b0}}, drop_inc};
        end
    end

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HDR;
            idx_q   <= '0;
            r_q     <= '0;
            hdr_q   <= '{default: '0};
            acc_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            r_q     <= r_d;
            hdr_q   <= hdr_d;
            acc_q   <= acc_d;
            drop_q  <= drop_d;
        end
    end

    assign stat_frames_accepted = acc_q;
    assign stat_frames_dropped  = drop_q;

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Directed bench for eth_rx_mac_filter: address filtering, runts, backpressure,
// bad-frame passthrough, asynchronous reset and counter clear.
module tb_eth_rx_mac_filter;

    logic        clock50 = 1'b0;
    logic        reset_n;
    logic [47:0] local_mac;
    logic        cfg_promiscuous, cfg_accept_broadcast, cfg_accept_multicast;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic        m_axis_tready = 1'b1;
    logic        stat_clear;
    logic [31:0] stat_frames_accepted, stat_frames_dropped;

    int          vec = 0;
    int          errs = 0;
    int          stalls = 0;
    int          mvalid_seen = 0;
    bit          bp_mode = 1'b0;
    logic [9:0]  outq [$];
    logic [7:0]  exp_bytes [0:127];

    localparam logic [47:0] MAC_ME    = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC_OTHER = 48'h02_00_00_00_00_02;
    localparam logic [47:0] MAC_BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MAC_MCAST = 48'h01_00_5E_00_00_01;

    eth_rx_mac_filter #(.COUNTER_WIDTH(32), .FILTER_ENABLE(1'b1)) dut (
        .clock50(clock50), .reset_n(reset_n), .local_mac(local_mac),
        .cfg_promiscuous(cfg_promiscuous), .cfg_accept_broadcast(cfg_accept_broadcast),
        .cfg_accept_multicast(cfg_accept_multicast),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .stat_clear(stat_clear), .stat_frames_accepted(stat_frames_accepted),
        .stat_frames_dropped(stat_frames_dropped)
    );

    always #10 clock50 = ~clock50;

    // Inputs change at posedge+1, so negedge values are what the next edge sees.
    initial forever begin
        @(negedge clock50);
        if (m_axis_tvalid) mvalid_seen++;
        if (m_axis_tvalid && m_axis_tready)
            outq.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    end

    initial forever begin
        @(posedge clock50);
        #1;
        if (bp_mode) m_axis_tready = ~m_axis_tready;
        else         m_axis_tready = 1'b1;
    end

    task automatic tick();
        @(posedge clock50);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic last, input logic user);
        bit hs = 1'b0;
        int unsigned n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        while (!hs && n < 200) begin
            @(negedge clock50);
            hs = s_axis_tready;
            if (!hs) stalls++;
            tick();
            n++;
        end
        if (!hs) begin
            vec++;
            errs++;
            $display("FAIL handshake_timeout: tready got 0 for %0d cycles, required 1", n);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] dest, input int len, input logic user,
                              input bit gaps, input bit clr_last);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = (i < 6) ? dest[47 - 8*i -: 8] : 8'(i * 7 + 3);
            exp_bytes[i] = b;
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            if (clr_last && i == len - 1) stat_clear = 1'b1;
            drive_byte(b, i == len - 1, (i == len - 1) ? user : 1'b0);
            stat_clear = 1'b0;
        end
        repeat (2) tick();
    endtask

    // Number of beats in outq that differ from the expected frame (size error counts too).
    function automatic int frame_bad(input int len, input logic user);
        int bad = 0;
        logic [9:0] e;
        if (outq.size() != len) bad++;
        for (int i = 0; i < len && i < outq.size(); i++) begin
            e = {(i == len - 1) ? user : 1'b0, i == len - 1, exp_bytes[i]};
            if (outq[i] !== e) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        vec++; if (s_axis_tready !== 1'b1) begin errs++; $display("FAIL rst_tready: got %b required 1", s_axis_tready); end
        vec++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 3'b000) begin errs++; $display("FAIL rst_mflags: got %b required 000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser}); end
        vec++; if (m_axis_tdata !== 8'h00) begin errs++; $display("FAIL rst_tdata: got %h required 00", m_axis_tdata); end
        vec++; if ({stat_frames_accepted, stat_frames_dropped} !== 64'd0) begin errs++; $display("FAIL rst_counters: got %0d/%0d required 0/0", stat_frames_accepted, stat_frames_dropped); end
        vec++; if (m_axis_tkeep !== 1'b1) begin errs++; $display("FAIL tkeep: got %b required 1", m_axis_tkeep); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_unicast();
        int nb;
        outq.delete();
        send_frame(MAC_ME, 64, 1'b0, 1'b0, 1'b0);
        nb = frame_bad(64, 1'b0);
        vec++; if (nb !== 0) begin errs++; $display("FAIL uc_frame: %0d bad beats (%0d beats out), required 0", nb, outq.size()); end
        vec++; if (stat_frames_accepted !== 32'd1 || stat_frames_dropped !== 32'd0) begin errs++; $display("FAIL uc_counters: got %0d/%0d required 1/0", stat_frames_accepted, stat_frames_dropped); end
        outq.delete();

        stalls = 0; mvalid_seen = 0;
        send_frame(MAC_OTHER, 64, 1'b0, 1'b0, 1'b0);
        vec++; if (mvalid_seen !== 0) begin errs++; $display("FAIL miss_no_output: %0d valid cycles, required 0", mvalid_seen); end
        vec++; if (stalls !== 0) begin errs++; $display("FAIL miss_tready: %0d stall cycles, required 0", stalls); end
        vec++; if (stat_frames_dropped !== 32'd1) begin errs++; $display("FAIL miss_dropped: got %0d required 1", stat_frames_dropped); end
    endtask

    task automatic test_bcast_mcast();
        int nb;
        outq.delete();
        cfg_accept_broadcast = 1'b0;
        send_frame(MAC_BCAST, 20, 1'b0, 1'b0, 1'b0);
        vec++; if (outq.size() !== 0 || stat_frames_dropped !== 32'd2) begin errs++; $display("FAIL bcast_off: out %0d dropped %0d, required 0/2", outq.size(), stat_frames_dropped); end
        outq.delete();
        cfg_accept_broadcast = 1'b1;
        send_frame(MAC_BCAST, 20, 1'b0, 1'b0, 1'b0);
        nb = frame_bad(20, 1'b0);
        vec++; if (nb !== 0 || stat_frames_accepted !== 32'd2) begin errs++; $display("FAIL bcast_on: bad %0d accepted %0d, required 0/2", nb, stat_frames_accepted); end
        outq.delete();
        cfg_accept_broadcast = 1'b0;
        cfg_accept_multicast = 1'b1;
        send_frame(MAC_MCAST, 20, 1'b0, 1'b0, 1'b0);
        nb = frame_bad(20, 1'b0);
        vec++; if (nb !== 0 || stat_frames_accepted !== 32'd3) begin errs++; $display("FAIL mcast_on: bad %0d accepted %0d, required 0/3", nb, stat_frames_accepted); end
        outq.delete();
        cfg_accept_multicast = 1'b0;
        send_frame(MAC_MCAST, 20, 1'b0, 1'b0, 1'b0);
        vec++; if (outq.size() !== 0 || stat_frames_dropped !== 32'd3) begin errs++; $display("FAIL mcast_off: out %0d dropped %0d, required 0/3", outq.size(), stat_frames_dropped); end
        outq.delete();
    endtask

    task automatic test_runts();
        int nb;
        outq.delete();
        send_frame(MAC_ME, 5, 1'b0, 1'b0, 1'b0);
        send_frame(MAC_ME, 6, 1'b0, 1'b0, 1'b0);
        vec++; if (outq.size() !== 0 || stat_frames_dropped !== 32'd5) begin errs++; $display("FAIL runts: out %0d dropped %0d, required 0/5", outq.size(), stat_frames_dropped); end
        send_frame(MAC_ME, 64, 1'b0, 1'b0, 1'b0);
        nb = frame_bad(64, 1'b0);
        vec++; if (nb !== 0 || stat_frames_accepted !== 32'd4) begin errs++; $display("FAIL after_runt: bad %0d accepted %0d, required 0/4", nb, stat_frames_accepted); end
        outq.delete();
    endtask

    task automatic test_backpressure();
        int nb;
        outq.delete();
        bp_mode = 1'b1;
        send_frame(MAC_ME, 64, 1'b0, 1'b1, 1'b0);
        nb = frame_bad(64, 1'b0);
        vec++; if (nb !== 0) begin errs++; $display("FAIL bp_frame: %0d bad beats (%0d out), required 0", nb, outq.size()); end
        outq.delete();
        send_frame(MAC_ME, 30, 1'b1, 1'b1, 1'b0);
        nb = frame_bad(30, 1'b1);
        vec++; if (nb !== 0 || stat_frames_accepted !== 32'd6) begin errs++; $display("FAIL bad_frame_tuser: bad %0d accepted %0d, required 0/6", nb, stat_frames_accepted); end
        bp_mode = 1'b0;
        repeat (2) tick();
        outq.delete();
    endtask

    task automatic test_reset_and_clear();
        for (int i = 0; i < 29; i++)
            drive_byte((i < 6) ? MAC_ME[47 - 8*i -: 8] : 8'(i), 1'b0, 1'b0);
        s_axis_tdata  = 8'hA5;
        s_axis_tvalid = 1'b1;
        #5;
        vec++; if (m_axis_tvalid !== 1'b1) begin errs++; $display("FAIL pre_reset_valid: got %b required 1", m_axis_tvalid); end
        reset_n = 1'b0;
        #1;
        vec++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 || s_axis_tready !== 1'b1) begin errs++; $display("FAIL midframe_reset: valid %b data %h tready %b, required 0 00 1", m_axis_tvalid, m_axis_tdata, s_axis_tready); end
        vec++; if (stat_frames_accepted !== 32'd0 || stat_frames_dropped !== 32'd0) begin errs++; $display("FAIL reset_counters: got %0d/%0d required 0/0", stat_frames_accepted, stat_frames_dropped); end
        s_axis_tvalid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        outq.delete();
        send_frame(MAC_ME, 16, 1'b0, 1'b0, 1'b0);
        vec++; if (frame_bad(16, 1'b0) !== 0 || stat_frames_accepted !== 32'd1) begin errs++; $display("FAIL post_reset_frame: accepted %0d, required 1", stat_frames_accepted); end
        outq.delete();
        send_frame(MAC_ME, 16, 1'b0, 1'b0, 1'b1);
        vec++; if (stat_frames_accepted !== 32'd0) begin errs++; $display("FAIL clear_priority: got %0d required 0", stat_frames_accepted); end
        outq.delete();
    endtask

    initial begin
        local_mac = MAC_ME;
        cfg_promiscuous = 1'b0;
        cfg_accept_broadcast = 1'b0;
        cfg_accept_multicast = 1'b0;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tuser = 1'b0;
        stat_clear = 1'b0;
        test_reset();
        test_unicast();
        test_bcast_mcast();
        test_runts();
        test_backpressure();
        test_reset_and_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
